lms_fir_param: RTL
==================

Name: lms_fir_param

Overview:
- Parametrised successor to the 128-tap LMS adaptive filter for the ANC datapath.
- Each accepted sample does two things in a single pass over the taps, using one time-multiplexed multiply pipeline:
  - updates the weights from the error of the previous output;
  - produces the next anti-noise output.
- Adds over the previous generation: generic tap count and widths, adapt freeze, optional weight leakage, weight clear, saturating arithmetic and an overrun flag.
- Sits between the reference-mic/error-mic sample front end and the speaker output stage.

Parameters:
- TAPS, 128, number of filter taps (>=2).
- DW, 16, signed sample, error and mu width (Q1.15).
- CW, 16, signed coefficient width (Q1.15).
- ACC_W, 48, accumulator width.
- OUT_W, 32, output width.
- LEAK_SHIFT, 8, leakage shift: w -= w>>>LEAK_SHIFT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample strobe; accepted only when in_ready=1
- in_ready  out  1  high in IDLE
- in_sample  in  DW  reference sample x[n]
- error_in  in  DW  error e for the previous output
- u_in  in  DW  step size mu, Q1.15, sampled at accept
- adapt_en  in  1  0 = weights frozen, sampled at accept
- leak_en  in  1  1 = apply leakage, sampled at accept
- clear_w  in  1  zero all weights; honoured only in IDLE
- out_sample  out  OUT_W  filter output y[n]
- out_valid  out  1  one-cycle pulse when out_sample is updated
- overrun  out  1  sticky: in_valid seen while in_ready=0

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - state IDLE;
  - in_ready=1, out_valid=0, out_sample=0, overrun=0;
  - all weights 0, delay line 0, write pointer 0.
  - Reset applied mid-RUN/DRAIN aborts the pass: no out_valid, and weights are cleared even if partially updated.
- Delay line:
  - circular buffer of TAPS+1 entries, pointer wraps TAPS->0;
  - at accept, x[n] is written at wptr;
  - the update step reads x[n-1-k]; the filter step reads x[n-k].
- FSM:
  - IDLE: in_valid=1 -> latch e, mu, adapt_en, leak_en; write x[n]; go to RUN with k=0.
  - RUN: issue tap k each cycle for k=0..TAPS-1, then go to DRAIN.
  - DRAIN: flush 2 pipeline stages, then go to DONE.
  - DONE: register out_sample, pulse out_valid, go to IDLE.
- Timing:
  - Accept-to-out_valid latency is exactly TAPS+3 cycles.
  - in_ready is low from the cycle after accept until IDLE is re-entered; minimum sample period is TAPS+4 cycles.
- Per-tap arithmetic (all signed, >>> is arithmetic shift, truncation toward -inf):
  - me = (mu*e)>>>15, saturated to DW; computed once per sample.
  - wl = leak_en ? w[k]-(w[k]>>>LEAK_SHIFT) : w[k].
  - w'[k] = adapt_en ? sat_CW(wl + ((me*x[n-1-k])>>>15)) : wl.
  - acc += w'[k]*x[n-k], in ACC_W bits with no wrap.
  - out_sample = sat_OUT_W(acc).
- Simultaneous events:
  - in_valid while busy is ignored, the sample is dropped and overrun is set; overrun clears only on rst.
  - clear_w with in_valid in IDLE: clear takes priority, and the sample is still accepted against zeroed weights.
  - clear_w outside IDLE is ignored.
- Saturation clamps to the two's-complement min/max of the target width.

Decomposition:
- Package lms_pkg holds:
  - the FSM state enum;
  - Q15 shift constant 15;
  - saturation functions sat_CW and sat_OUT_W;
  - the pipeline depth constant 2.
- Sub-module lms_tap_alu: the 2-stage pipelined update-and-MAC datapath for one tap per cycle, carrying the update multiply, leakage, saturation and product.
- Weight and delay storage, pointer logic and the FSM live in the top.

Test Plan (TAPS=4 unless noted):
- u_in=0, x=1000,2000,3000 -> out_sample 0 each time; out_valid exactly 7 cycles after each accept; in_ready low for the 7 cycles after accept.
- mu=16384, e=16384, x=1000 then x=2000 -> 1st out 0; 2nd accept gives w0=250 and out_sample=500000.
- After the previous scenario: leak_en=1, LEAK_SHIFT=2, adapt_en=0, mu=0, x=2000 -> w0=188, out_sample=376000.
- mu=e=x=32767 repeated 20 samples -> every weight clamps at 32767 with no wrap; out_sample=2147483647.
- in_valid pulse 2 cycles after an accept -> ignored; overrun=1 and stays 1; the next out_sample matches the single-sample result.
- rst during RUN, then x=1000 with mu=0 -> no out_valid from the aborted pass; in_ready=1 the cycle after rst; new output 0 with weights cleared.

Source files
------------

// File: rtl/lms_pkg.sv
// lms_pkg: FSM states, Q15/pipeline constants and saturation helpers for the LMS FIR
package lms_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int Q15 = 15;
  localparam int PIPE = 2;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : (v < -hi - 64'sd1 ? -hi - 64'sd1 : v);
  endfunction
  function automatic logic signed [63:0] sat_cw(input logic signed [63:0] v, input int cw);
    return sat(v, cw);
  endfunction
  function automatic logic signed [63:0] sat_out_w(input logic signed [63:0] v, input int ow);
    return sat(v, ow);
  endfunction
endpackage

// File: rtl/lms_tap_alu.sv
// lms_tap_alu: two-stage per-tap leak/update and weight-times-sample pipeline
module lms_tap_alu
  import lms_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int KW = 7,
  parameter int LEAK_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iv,
  input  logic [KW-1:0]           k_in,
  input  logic signed [CW-1:0]    w_in,
  input  logic signed [DW-1:0]    x_old,
  input  logic signed [DW-1:0]    x_new,
  input  logic signed [DW-1:0]    me,
  input  logic                    adapt,
  input  logic                    leak,
  output logic                    ov,
  output logic [KW-1:0]           k_out,
  output logic signed [CW-1:0]    w_out,
  output logic signed [CW+DW-1:0] prod
);
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [KW-1:0] s1_k_q, s1_k_d, s2_k_q, s2_k_d;
  logic signed [CW-1:0] s1_wl_q, s1_wl_d, s2_w_q, s2_w_d;
  logic signed [2*DW-1:0] s1_up_q, s1_up_d;
  logic signed [DW-1:0] s1_x_q, s1_x_d;
  logic signed [CW+DW-1:0] s2_p_q, s2_p_d;
  always_comb begin
    s1_v_d = iv;
    s1_k_d = k_in;
    s1_wl_d = leak ? w_in - (w_in >>> LEAK_SHIFT) : w_in;
    s1_up_d = ((2*DW)'(me) * (2*DW)'(x_old)) >>> Q15;
    s1_x_d = x_new;
    s2_v_d = s1_v_q;
    s2_k_d = s1_k_q;
    s2_w_d = adapt ? CW'(sat_cw(64'(s1_wl_q) + 64'(s1_up_q), CW)) : s1_wl_q;
    s2_p_d = (CW+DW)'(s2_w_d) * (CW+DW)'(s1_x_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_k_q <= '0;
      s2_k_q <= '0;
      s1_wl_q <= '0;
      s1_up_q <= '0;
      s1_x_q <= '0;
      s2_w_q <= '0;
      s2_p_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_k_q <= s1_k_d;
      s2_k_q <= s2_k_d;
      s1_wl_q <= s1_wl_d;
      s1_up_q <= s1_up_d;
      s1_x_q <= s1_x_d;
      s2_w_q <= s2_w_d;
      s2_p_q <= s2_p_d;
    end
  end
  assign ov = s2_v_q;
  assign k_out = s2_k_q;
  assign w_out = s2_w_q;
  assign prod = s2_p_q;
endmodule

// File: rtl/lms_fir_param.sv
// lms_fir_param: parametrised LMS adaptive FIR, one tap per cycle over a shared update/MAC pipeline
module lms_fir_param
  import lms_pkg::*;
#(
  parameter int TAPS = 128,
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int LEAK_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_sample,
  input  logic signed [DW-1:0]    error_in,
  input  logic signed [DW-1:0]    u_in,
  input  logic                    adapt_en,
  input  logic                    leak_en,
  input  logic                    clear_w,
  output logic signed [OUT_W-1:0] out_sample,
  output logic                    out_valid,
  output logic                    overrun
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = $clog2(TAPS + 1);
  state_t st_q, st_d;
  logic [KW-1:0] k_q, k_d, a_k;
  logic [PW-1:0] wptr_q, wptr_d, rn_q, rn_d, ro;
  logic signed [DW-1:0] dl_q [TAPS+1];
  logic signed [DW-1:0] dl_d [TAPS+1];
  logic signed [CW-1:0] w_q [TAPS];
  logic signed [CW-1:0] w_d [TAPS];
  logic signed [DW-1:0] me_q, me_d;
  logic adapt_q, adapt_d, leak_q, leak_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic ov_q, ov_d, overrun_q, overrun_d;
  logic a_v;
  logic signed [CW-1:0] a_w;
  logic signed [CW+DW-1:0] a_p;
  assign ro = rn_q == '0 ? PW'(TAPS) : rn_q - PW'(1);
  lms_tap_alu #(.DW(DW), .CW(CW), .KW(KW), .LEAK_SHIFT(LEAK_SHIFT)) u_alu (
    .clk(clk),
    .rst(rst),
    .iv(st_q == S_RUN),
    .k_in(k_q),
    .w_in(w_q[k_q]),
    .x_old(dl_q[ro]),
    .x_new(dl_q[rn_q]),
    .me(me_q),
    .adapt(adapt_q),
    .leak(leak_q),
    .ov(a_v),
    .k_out(a_k),
    .w_out(a_w),
    .prod(a_p)
  );
  always_comb begin
    st_d = st_q;
    k_d = k_q;
    rn_d = rn_q;
    wptr_d = wptr_q;
    dl_d = dl_q;
    w_d = w_q;
    me_d = me_q;
    adapt_d = adapt_q;
    leak_d = leak_q;
    acc_d = acc_q;
    out_d = out_q;
    ov_d = 1'b0;
    overrun_d = overrun_q | (in_valid & (st_q != S_IDLE));
    if (a_v) begin
      w_d[a_k] = a_w;
      acc_d = acc_q + ACC_W'(a_p);
    end
    unique case (st_q)
      S_IDLE: begin
        if (clear_w) w_d = '{default: '0};
        if (in_valid) begin
          dl_d[wptr_q] = in_sample;
          rn_d = wptr_q;
          wptr_d = wptr_q == PW'(TAPS) ? '0 : wptr_q + PW'(1);
          me_d = DW'(sat((64'(u_in) * 64'(error_in)) >>> Q15, DW));
          adapt_d = adapt_en;
          leak_d = leak_en;
          acc_d = '0;
          k_d = '0;
          st_d = S_RUN;
        end
      end
      S_RUN: begin
        rn_d = ro;
        k_d = k_q == KW'(TAPS - 1) ? '0 : k_q + KW'(1);
        st_d = k_q == KW'(TAPS - 1) ? S_DRAIN : S_RUN;
      end
      S_DRAIN: begin
        k_d = k_q + KW'(1);
        st_d = k_q == KW'(PIPE - 1) ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        out_d = OUT_W'(sat_out_w(64'(acc_q), OUT_W));
        ov_d = 1'b1;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      k_q <= '0;
      rn_q <= '0;
      wptr_q <= '0;
      dl_q <= '{default: '0};
      w_q <= '{default: '0};
      me_q <= '0;
      adapt_q <= 1'b0;
      leak_q <= 1'b0;
      acc_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      st_q <= st_d;
      k_q <= k_d;
      rn_q <= rn_d;
      wptr_q <= wptr_d;
      dl_q <= dl_d;
      w_q <= w_d;
      me_q <= me_d;
      adapt_q <= adapt_d;
      leak_q <= leak_d;
      acc_q <= acc_d;
      out_q <= out_d;
      ov_q <= ov_d;
      overrun_q <= overrun_d;
    end
  end
  assign in_ready = st_q == S_IDLE;
  assign out_sample = out_q;
  assign out_valid = ov_q;
  assign overrun = overrun_q;
endmodule
